// File: rtl/npc_pkg.sv
// Shared fetch-stage definitions.
// State encoding, reset PC and PC helpers.
package npc_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;

  localparam logic [2:0] S_BOOT = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  function automatic logic pc_ok(
    input logic [XLEN-1:0] p
  );
    return p[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, one fetch in flight,
// hands {inst, inst_pc} to the core and waits for its next PC.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned     CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [XLEN-1:0]  mem_req_addr,
  input  logic             mem_rsp_valid,
  input  logic [XLEN-1:0]  mem_rsp_data,
  input  logic             mem_rsp_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [XLEN-1:0]  inst,
  output logic [XLEN-1:0]  inst_pc,
  input  logic             nxt_valid,
  input  logic [XLEN-1:0]  nxt_pc,
  output logic             fetch_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  logic [2:0]       state_d;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_d;
  logic [XLEN-1:0]  inst_d;
  logic [XLEN-1:0]  ipc_d;
  logic             err_d;
  logic [CNT_W-1:0] cnt_d;
  logic             take_nxt;

  assign mem_req_valid = (state == S_REQ);
  assign inst_valid    = (state == S_OUT);
  assign mem_req_addr  = pc;

  // Next PC is taken while waiting for it, or together
  // with the instruction handshake.
  assign take_nxt = nxt_valid &&
    ((state == S_NEXT) ||
     ((state == S_OUT) && inst_ready));

  // Next-state and datapath update for the fetch sequence.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    inst_d  = inst;
    ipc_d   = inst_pc;
    err_d   = fetch_err;
    cnt_d   = fetch_cnt;
    case (state)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_err) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            inst_d  = mem_rsp_data;
            ipc_d   = pc;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (inst_ready) begin
          cnt_d   = fetch_cnt + CNT_ONE;
          state_d = S_NEXT;
        end
      end
      S_NEXT: state_d = S_NEXT;
      S_HALT: state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
    if (take_nxt) begin
      if (pc_ok(nxt_pc)) begin
        pc_d    = nxt_pc;
        state_d = S_REQ;
      end else begin
        err_d   = 1'b1;
        state_d = S_HALT;
      end
    end
  end

  // State, PC, instruction latch and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_BOOT;
      pc        <= RESET_PC;
      inst      <= '0;
      inst_pc   <= '0;
      fetch_err <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      inst      <= inst_d;
      inst_pc   <= ipc_d;
      fetch_err <= err_d;
      fetch_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: transaction-level model plus
// directed fetch sequences with literal expectations.
module tb_ifu_fetch;
  import npc_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        nxt_valid;
  logic [31:0] nxt_pc;
  logic        fetch_err;
  logic [63:0] fetch_cnt;

  int n_chk = 0;
  int n_fail = 0;

  ifu_fetch dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .mem_rsp_err(mem_rsp_err),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .nxt_valid(nxt_valid), .nxt_pc(nxt_pc),
    .fetch_err(fetch_err),
    .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memw(
    input logic [31:0] a
  );
    if (a == 32'h8000_0000) return 32'h0000_0513;
    return {a[15:0], ~a[31:16]};
  endfunction

  // Transaction model: what has been asked, what is owed.
  bit          m_boot = 1'b1;
  bit          m_out  = 1'b0;
  bit          m_have = 1'b0;
  bit          m_need = 1'b0;
  bit          m_err  = 1'b0;
  logic [31:0] m_pc   = 32'h8000_0000;
  logic [31:0] m_inst = '0;
  logic [31:0] m_ipc  = '0;
  logic [63:0] m_cnt  = '0;

  function automatic bit exp_rv();
    return !m_boot && !m_out && !m_have &&
           !m_need && !m_err;
  endfunction

  function automatic bit exp_iv();
    return m_have && !m_err;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_boot = 1'b1; m_out = 1'b0;
        m_have = 1'b0; m_need = 1'b0;
        m_err = 1'b0; m_pc = 32'h8000_0000;
        m_inst = '0; m_ipc = '0; m_cnt = '0;
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else if (!m_err) begin
        bit o, h, n, hs;
        o = m_out; h = m_have; n = m_need;
        hs = h && inst_ready;
        if (o && mem_rsp_valid) begin
          m_out = 1'b0;
          if (mem_rsp_err) m_err = 1'b1;
          else begin
            m_have = 1'b1;
            m_inst = mem_rsp_data;
            m_ipc  = m_pc;
          end
        end else if (!o && !h && !n && mem_req_ready) begin
          m_out = 1'b1;
        end
        if (hs) begin
          m_have = 1'b0;
          m_cnt  = m_cnt + 64'd1;
        end
        if ((hs || n) && nxt_valid) begin
          m_need = 1'b0;
          if (nxt_pc[1:0] == 2'b00) m_pc = nxt_pc;
          else m_err = 1'b1;
        end else if (hs) begin
          m_need = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_req_valid", 64'(mem_req_valid), 64'(exp_rv()));
      chk("m_req_addr", 64'(mem_req_addr), 64'(m_pc));
      chk("m_inst_valid", 64'(inst_valid), 64'(exp_iv()));
      chk("m_inst", 64'(inst), 64'(m_inst));
      chk("m_inst_pc", 64'(inst_pc), 64'(m_ipc));
      chk("m_fetch_err", 64'(fetch_err), 64'(m_err));
      chk("m_fetch_cnt", fetch_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input string nm);
    int k;
    k = 0;
    while (mem_req_valid !== 1'b1 && k < 30) begin
      tick(); k++;
    end
    if (k >= 30) chk(nm, 64'd0, 64'd1);
  endtask

  task automatic wait_inst(input string nm);
    int k;
    k = 0;
    while (inst_valid !== 1'b1 && k < 30) begin
      tick(); k++;
    end
    if (k >= 30) chk(nm, 64'd0, 64'd1);
  endtask

  task automatic do_req(input logic [31:0] ea,
                        input int stall);
    wait_req("req_timeout");
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", 64'(mem_req_valid), 64'd1);
      chk("stall_addr", 64'(mem_req_addr), 64'(ea));
      tick();
    end
    chk("req_addr", 64'(mem_req_addr), 64'(ea));
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
  endtask

  task automatic do_rsp(input logic [31:0] a,
                        input int dly, input bit err);
    for (int i = 0; i < dly; i++) tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = memw(a);
    mem_rsp_err   = err;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
  endtask

  task automatic do_out(input int stall,
                        input logic [31:0] npc);
    wait_inst("inst_timeout");
    for (int i = 0; i < stall; i++) tick();
    inst_ready = 1'b1;
    nxt_valid  = 1'b1;
    nxt_pc     = npc;
    tick();
    inst_ready = 1'b0;
    nxt_valid  = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_addr", 64'(mem_req_addr), 64'h8000_0000);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", 64'(inst_pc), 64'd0);
    chk("rst_err", 64'(fetch_err), 64'd0);
    chk("rst_cnt", fetch_cnt, 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_err   = 1'b0;
    inst_ready    = 1'b0;
    nxt_valid     = 1'b0;
    nxt_pc        = '0;
    tick(); tick();
    chk_reset_vals();

    // Boot and minimum-latency first fetch.
    rst = 1'b1;
    chk("boot_idle", 64'(mem_req_valid), 64'd0);
    tick();
    chk("boot_req", 64'(mem_req_valid), 64'd1);
    chk("boot_addr", 64'(mem_req_addr), 64'h8000_0000);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("t1_no_req", 64'(mem_req_valid), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_0513;
    tick();
    mem_rsp_valid = 1'b0;
    chk("t2_inst_valid", 64'(inst_valid), 64'd1);
    chk("t2_inst", 64'(inst), 64'h0000_0513);
    chk("t2_inst_pc", 64'(inst_pc), 64'h8000_0000);

    // Core stalls two cycles, then takes inst and next PC.
    tick(); tick();
    chk("held_inst", 64'(inst), 64'h0000_0513);
    chk("held_valid", 64'(inst_valid), 64'd1);
    do_out(0, 32'h8000_0004);
    chk("cnt_one", fetch_cnt, 64'd1);
    chk("next_addr", 64'(mem_req_addr), 64'h8000_0004);

    // Memory stalls three cycles; stray traffic in S_NEXT.
    do_req(32'h8000_0004, 3);
    do_rsp(32'h8000_0004, 1, 1'b0);
    wait_inst("inst_timeout");
    chk("inst2", 64'(inst), 64'(memw(32'h8000_0004)));
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_err   = 1'b1;
    mem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    tick();
    chk("stray_err", 64'(fetch_err), 64'd0);
    chk("stray_req", 64'(mem_req_valid), 64'd0);
    nxt_valid = 1'b1;
    nxt_pc    = 32'hFFFF_FFFC;
    tick();
    nxt_valid = 1'b0;
    chk("cnt_two", fetch_cnt, 64'd2);

    // Top-of-memory PC; stray next PC while waiting.
    do_req(32'hFFFF_FFFC, 0);
    nxt_valid = 1'b1;
    nxt_pc    = 32'h8000_0006;
    tick();
    nxt_valid = 1'b0;
    chk("wait_nxt_err", 64'(fetch_err), 64'd0);
    do_rsp(32'hFFFF_FFFC, 0, 1'b0);
    chk("top_inst_pc", 64'(inst_pc), 64'hFFFF_FFFC);

    // Misaligned next PC halts the stage.
    do_out(1, 32'h8000_0006);
    chk("mis_err", 64'(fetch_err), 64'd1);
    chk("mis_cnt", fetch_cnt, 64'd3);
    mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_req", 64'(mem_req_valid), 64'd0);
      chk("halt_pc", 64'(mem_req_addr), 64'hFFFF_FFFC);
    end
    mem_req_ready = 1'b0;

    // Reset in the middle of a fetch; late response dropped.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    do_req(32'h8000_0000, 0);
    rst = 1'b0;
    tick();
    chk_reset_vals();
    rst = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1111_2222;
    tick();
    tick();
    mem_rsp_valid = 1'b0;
    chk("drop_inst_valid", 64'(inst_valid), 64'd0);
    chk("drop_req", 64'(mem_req_valid), 64'd1);
    chk("drop_inst", 64'(inst), 64'd0);
    do_req(32'h8000_0000, 0);
    do_rsp(32'h8000_0000, 0, 1'b0);
    chk("refetch_inst", 64'(inst), 64'h0000_0513);
    do_out(0, 32'h8000_0008);

    // Access fault on the response halts the stage.
    do_req(32'h8000_0008, 0);
    do_rsp(32'h8000_0008, 2, 1'b1);
    chk("rsp_err", 64'(fetch_err), 64'd1);
    chk("rsp_err_cnt", fetch_cnt, 64'd1);
    chk("rsp_err_inst", 64'(inst), 64'h0000_0513);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rsp_halt_req", 64'(mem_req_valid), 64'd0);
      chk("rsp_halt_iv", 64'(inst_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
